// File: rtl/pe_psum_acc_pkg.sv
// -----------------------------------------------------------------------------
// pe_psum_acc_pkg
// Shared types and sizing for the PE partial-sum accumulation stage.
//   - psum / Aunit product widths and psum pad geometry
//   - SSctl beat-control struct and ShtNum shift selector
//   - accumulator FSM state constants
//   - sht_amount(): bit-serial shift distance for a ShtNum code
// -----------------------------------------------------------------------------
package pe_psum_acc_pkg;

    localparam int PSUM_DW   = 16;
    localparam int AU_DW     = 16;
    localparam int PPAD_SIZE = 64;
    localparam int PPAD_AW   = $clog2(PPAD_SIZE);

    typedef logic [PPAD_AW-1:0] ppad_addr_t;

    // Bit-serial shift selector: the pad value is shifted by 1, 2, 4 or 8.
    typedef enum logic [1:0] {
        SHT1 = 2'd0,
        SHT2 = 2'd1,
        SHT4 = 2'd2,
        SHT8 = 2'd3
    } sht_num_e;

    // Per-beat control from the sub-system controller. The valid field is
    // carried for compatibility only; the stage uses its own handshake.
    typedef struct packed {
        logic     valid;
        logic     init;
        logic     fstpix;
        logic     lstpix;
        logic     sht;
        sht_num_e sht_num;
    } ss_ctl_t;

    // Accumulator FSM states.
    typedef logic [0:0] psum_acc_state_t;
    localparam psum_acc_state_t ST_RUN   = 1'b0;
    localparam psum_acc_state_t ST_CLEAR = 1'b1;

    // Shift distance selected by a ShtNum code.
    function automatic logic [3:0] sht_amount(input sht_num_e n);
        logic [3:0] amt;
        case (n)
            SHT1:    amt = 4'd1;
            SHT2:    amt = 4'd2;
            SHT4:    amt = 4'd4;
            SHT8:    amt = 4'd8;
            default: amt = 4'd1;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/pe_psum_acc_ppad.sv
// -----------------------------------------------------------------------------
// pe_ppad
// Psum pad register file: DEPTH x DW, one synchronous read port and one
// write port. No reset; contents are initialised by the owner's clear sweep.
// A read and a write to the same entry on the same edge returns the old
// value; the owner bypasses that case itself.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (rdata updates only when set)
//   raddr  in   read address
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module pe_ppad #(
    parameter int DW    = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Synchronous read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/pe_psum_acc.sv
// -----------------------------------------------------------------------------
// pe_psum_acc
// Partial-sum accumulation stage of the PE. Each accepted Aunit product is
// added into an entry of the psum pad (read-modify-write) with optional
// first-pixel / external initialisation and bit-serial shift of the old value.
// Finished psums (lstpix) are presented on a valid/ready output.
// Two-stage pipeline: S1 captures the beat and reads the pad, S2 computes
// the new sum, writes it back and optionally loads the output register.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_valid/ready input beat handshake
//   i_au          signed Aunit product
//   i_ctl         beat control (init/fstpix/lstpix/sht/sht_num)
//   i_addr        psum pad entry
//   i_initpsum    external initial psum, used when init=1
//   i_clear       one-cycle pulse: zero the whole pad
//   o_valid/ready finished psum handshake
//   o_psum/o_addr finished psum and its pad entry
//   o_busy        clearing, or a beat is in flight
// -----------------------------------------------------------------------------
module pe_psum_acc
    import pe_psum_acc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [AU_DW-1:0]   i_au,
    input  ss_ctl_t            i_ctl,
    input  logic [PPAD_AW-1:0] i_addr,
    input  logic [PSUM_DW-1:0] i_initpsum,
    input  logic               i_clear,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [PSUM_DW-1:0] o_psum,
    output logic [PPAD_AW-1:0] o_addr,
    output logic               o_busy
);

    // FSM / clear control
    psum_acc_state_t    state_r;
    logic [PPAD_AW-1:0] clr_cnt_r;
    logic               clear_pend_r;
    logic               clear_req_s;
    logic               drained_s;

    // Handshake
    logic               en_s;
    logic               accept_s;

    // S1
    logic               s1_valid_r;
    logic [AU_DW-1:0]   s1_au_r;
    ss_ctl_t            s1_ctl_r;
    logic [PPAD_AW-1:0] s1_addr_r;
    logic [PSUM_DW-1:0] s1_init_r;
    logic               byp_hit_r;
    logic [PSUM_DW-1:0] byp_data_r;
    logic [PSUM_DW-1:0] ppad_rd_s;
    logic [PSUM_DW-1:0] s1_rd_s;
    logic [PSUM_DW-1:0] rd_fwd_s;

    // S2
    logic               s2_valid_r;
    logic [AU_DW-1:0]   s2_au_r;
    ss_ctl_t            s2_ctl_r;
    logic [PPAD_AW-1:0] s2_addr_r;
    logic [PSUM_DW-1:0] s2_init_r;
    logic [PSUM_DW-1:0] s2_rd_r;
    logic [PSUM_DW-1:0] s2_au_ext_s;
    logic [PSUM_DW-1:0] s2_base_s;
    logic [PSUM_DW-1:0] s2_shifted_s;
    logic [PSUM_DW-1:0] s2_sum_s;

    // Pad write port
    logic               wr_en_s;
    logic [PPAD_AW-1:0] wr_addr_s;
    logic [PSUM_DW-1:0] wr_data_s;

    // Output registers
    logic               o_valid_r;
    logic [PSUM_DW-1:0] o_psum_r;
    logic [PPAD_AW-1:0] o_addr_r;

    // ------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------
    // The whole pipeline advances only when the output is not blocked.
    assign en_s        = !(o_valid_r && !o_ready);
    // A clear pulse blocks input in its own cycle so nothing new enters S1.
    assign clear_req_s = i_clear || clear_pend_r;
    assign drained_s   = !s1_valid_r && !s2_valid_r;
    assign i_ready     = (state_r == ST_RUN) && en_s && !clear_req_s;
    assign accept_s    = i_valid && i_ready;
    assign o_busy      = (state_r == ST_CLEAR) || s1_valid_r || s2_valid_r;

    // FSM: CLEAR sweeps every pad entry, RUN accumulates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_CLEAR;
            clr_cnt_r    <= '0;
            clear_pend_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clear_pend_r <= 1'b0;
                    if (i_clear) begin
                        clr_cnt_r <= '0;
                    end else if (clr_cnt_r == PPAD_AW'(PPAD_SIZE - 1)) begin
                        state_r   <= ST_RUN;
                        clr_cnt_r <= '0;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Let in-flight beats finish before the sweep starts.
                    if (clear_req_s && drained_s) begin
                        state_r      <= ST_CLEAR;
                        clr_cnt_r    <= '0;
                        clear_pend_r <= 1'b0;
                    end else begin
                        clear_pend_r <= clear_req_s;
                    end
                end
                default: begin
                    state_r      <= ST_CLEAR;
                    clr_cnt_r    <= '0;
                    clear_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Psum pad
    // ------------------------------------------------------------------
    // Write port: the clear sweep owns it in CLEAR, S2 write-back in RUN.
    always_comb begin
        if (state_r == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_cnt_r;
            wr_data_s = '0;
        end else begin
            wr_en_s   = en_s && s2_valid_r;
            wr_addr_s = s2_addr_r;
            wr_data_s = s2_sum_s;
        end
    end

    pe_ppad #(
        .DW    (PSUM_DW),
        .DEPTH (PPAD_SIZE),
        .AW    (PPAD_AW)
    ) u_ppad (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_addr_s),
        .wdata (wr_data_s),
        .re    (accept_s),
        .raddr (i_addr),
        .rdata (ppad_rd_s)
    );

    // ------------------------------------------------------------------
    // S1: beat capture and pad read
    // ------------------------------------------------------------------
    // S1 registers. The pad read on the accept edge misses a write landing
    // on that same edge, so that write is captured here as a bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_au_r    <= '0;
            s1_ctl_r   <= '0;
            s1_addr_r  <= '0;
            s1_init_r  <= '0;
            byp_hit_r  <= 1'b0;
            byp_data_r <= '0;
        end else if (en_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_au_r    <= i_au;
                s1_ctl_r   <= i_ctl;
                s1_addr_r  <= i_addr;
                s1_init_r  <= i_initpsum;
                byp_hit_r  <= wr_en_s && (wr_addr_s == i_addr);
                byp_data_r <= wr_data_s;
            end
        end
    end

    assign s1_rd_s  = byp_hit_r ? byp_data_r : ppad_rd_s;
    // S2 writes back on the same edge S1 advances; use its result directly.
    assign rd_fwd_s = (s2_valid_r && (s2_addr_r == s1_addr_r)) ? s2_sum_s : s1_rd_s;

    // ------------------------------------------------------------------
    // S2: compute and write back
    // ------------------------------------------------------------------
    // S2 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_au_r    <= '0;
            s2_ctl_r   <= '0;
            s2_addr_r  <= '0;
            s2_init_r  <= '0;
            s2_rd_r    <= '0;
        end else if (en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_au_r   <= s1_au_r;
                s2_ctl_r  <= s1_ctl_r;
                s2_addr_r <= s1_addr_r;
                s2_init_r <= s1_init_r;
                s2_rd_r   <= rd_fwd_s;
            end
        end
    end

    assign s2_au_ext_s = PSUM_DW'($signed(s2_au_r));

    // New psum: select base (fstpix > init > pad), optional shift, add product.
    always_comb begin
        if (s2_ctl_r.fstpix) begin
            s2_base_s = '0;
        end else if (s2_ctl_r.init) begin
            s2_base_s = s2_init_r;
        end else begin
            s2_base_s = s2_rd_r;
        end
        if (s2_ctl_r.sht) begin
            s2_shifted_s = s2_base_s << sht_amount(s2_ctl_r.sht_num);
        end else begin
            s2_shifted_s = s2_base_s;
        end
        s2_sum_s = s2_shifted_s + s2_au_ext_s;
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // Load on a finished psum; drop valid after handshake otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_r <= 1'b0;
            o_psum_r  <= '0;
            o_addr_r  <= '0;
        end else if (en_s) begin
            if (s2_valid_r && s2_ctl_r.lstpix) begin
                o_valid_r <= 1'b1;
                o_psum_r  <= s2_sum_s;
                o_addr_r  <= s2_addr_r;
            end else begin
                o_valid_r <= 1'b0;
            end
        end
    end

    assign o_valid = o_valid_r;
    assign o_psum  = o_psum_r;
    assign o_addr  = o_addr_r;

endmodule
